// File: rtl/acc_shift_rs.sv
// -----------------------------------------------------------------------------
// acc_shift_rs -- multi-channel pipelined accumulator rescaler
//
// Takes CH signed DW-bit accumulator values per beat and, for every channel,
// arithmetic-right-shifts by the beat's shift amount (optionally rounding
// half toward +inf), then saturates the result to a signed OW-bit value.
// It sits between the MAC accumulator array and the output
// requantisation/writeback path. A saturation-event counter supports
// calibration of the shift amounts.
//
// Configuration macro:
//   ACC_SHIFT_RS_ROUND_EN  defined     : stage 1 adds 2^(sh-1) before the
//                                        shift (round-half-up), DW+1-bit path
//                          not defined : stage 1 is a pure arithmetic shift
//                                        (floor), DW-bit path
//   Pipeline depth, handshake and saturation behave the same either way.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   m_valid    in   input beat valid
//   m_ready    out  block can accept a beat (combinational from s_ready)
//   m_data     in   CH*DW, channel i at [i*DW +: DW], signed
//   m_shift_n  in   SW, shift amount for all channels of the beat
//   s_valid    out  output beat valid (registered)
//   s_ready    in   downstream accepts
//   s_data     out  CH*OW, channel i at [i*OW +: OW], signed
//   s_sat      out  CH, per-channel saturation flag aligned with s_data
//   sat_clr    in   clears sat_cnt / sat_flag
//   sat_cnt    out  CW, saturated channel results transferred since clear
//                   (sticks at all-ones)
//   sat_flag   out  sticky: at least one saturation since clear
// -----------------------------------------------------------------------------
module acc_shift_rs #(
   parameter int CH = 2,
   parameter int DW = 22,
   parameter int OW = 16,
   parameter int SW = 3,
   parameter int CW = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m_valid,
   output logic                m_ready,
   input  logic [CH*DW-1:0]    m_data,
   input  logic [SW-1:0]       m_shift_n,
   output logic                s_valid,
   input  logic                s_ready,
   output logic [CH*OW-1:0]    s_data,
   output logic [CH-1:0]       s_sat,
   input  logic                sat_clr,
   output logic [CW-1:0]       sat_cnt,
   output logic                sat_flag
);

   // Width of the shifted intermediate held between the two stages. The
   // rounding offset needs one extra bit so the addition cannot overflow.
`ifdef ACC_SHIFT_RS_ROUND_EN
   localparam int TW = DW + 1;
`else
   localparam int TW = DW;
`endif

   localparam int PW = $clog2(CH + 1);

   // Output range limits expressed at the intermediate width.
   localparam logic signed [TW-1:0] OMAX = {{(TW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [TW-1:0] OMIN = {{(TW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   // ---------------------------------------------------------------------
   // Arithmetic helpers
   // ---------------------------------------------------------------------

   // Shift one channel, adding half an LSB of the result first when
   // rounding is built in (so ties go toward +inf).
   function automatic logic signed [TW-1:0] shift_ch(
      input logic signed [DW-1:0] a,
      input logic        [SW-1:0] sh
   );
`ifdef ACC_SHIFT_RS_ROUND_EN
      logic signed [TW-1:0] ofs;
      logic signed [TW-1:0] r;
      ofs = '0;
      if (sh != '0) begin
         ofs = TW'(1) << (sh - 1'b1);
      end
      r = $signed({a[DW-1], a}) + ofs;
      return r >>> sh;
`else
      return a >>> sh;
`endif
   endfunction

   // Clamp a shifted value to the signed OW-bit range.
   function automatic logic [OW-1:0] sat_val(input logic signed [TW-1:0] t);
      if (t > OMAX) begin
         return OMAX[OW-1:0];
      end else if (t < OMIN) begin
         return OMIN[OW-1:0];
      end else begin
         return t[OW-1:0];
      end
   endfunction

   function automatic logic sat_hit(input logic signed [TW-1:0] t);
      return (t > OMAX) || (t < OMIN);
   endfunction

   function automatic logic [PW-1:0] popcnt(input logic [CH-1:0] f);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < CH; i++) begin
         p = p + PW'(f[i]);
      end
      return p;
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CW-1:0] cnt_add(
      input logic [CW-1:0] c,
      input logic [PW-1:0] p
   );
      logic [CW:0] s;
      s = {1'b0, c} + (CW+1)'(p);
      return s[CW] ? {CW{1'b1}} : s[CW-1:0];
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                v_p1_q, v_p1_d;
   logic [CH*TW-1:0]    t_p1_q, t_p1_d;
   logic                v_p2_q, v_p2_d;
   logic [CH*OW-1:0]    dat_p2_q, dat_p2_d;
   logic [CH-1:0]       sat_p2_q, sat_p2_d;
   logic [CW-1:0]       sat_cnt_q, sat_cnt_d;
   logic                sat_flag_q, sat_flag_d;

   logic                ld_p1, ld_p2, acc, xfer;
   logic [PW-1:0]       pc_p2;

   // Stage 2 advances whenever its slot is empty or being drained; stage 1
   // advances whenever its slot is empty or moving into stage 2. This gives
   // full throughput and a ready that looks through both stages.
   assign ld_p2   = !v_p2_q || s_ready;
   assign ld_p1   = !v_p1_q || ld_p2;
   assign acc     = m_valid && ld_p1;
   assign xfer    = v_p2_q && s_ready;
   assign pc_p2   = popcnt(sat_p2_q);

   assign m_ready  = ld_p1;
   assign s_valid  = v_p2_q;
   assign s_data   = dat_p2_q;
   assign s_sat    = sat_p2_q;
   assign sat_cnt  = sat_cnt_q;
   assign sat_flag = sat_flag_q;

   // ---- stage 1: rounding offset + arithmetic shift ----
   always_comb begin
      v_p1_d = v_p1_q;
      t_p1_d = t_p1_q;
      if (ld_p1) begin
         v_p1_d = m_valid;
      end
      if (acc) begin
         for (int i = 0; i < CH; i++) begin
            t_p1_d[i*TW +: TW] = shift_ch(m_data[i*DW +: DW], m_shift_n);
         end
      end
   end

   // ---- stage 2: saturation to OW bits ----
   always_comb begin
      v_p2_d   = v_p2_q;
      dat_p2_d = dat_p2_q;
      sat_p2_d = sat_p2_q;
      if (ld_p2) begin
         v_p2_d = v_p1_q;
         if (v_p1_q) begin
            for (int i = 0; i < CH; i++) begin
               dat_p2_d[i*OW +: OW] = sat_val(t_p1_q[i*TW +: TW]);
               sat_p2_d[i]          = sat_hit(t_p1_q[i*TW +: TW]);
            end
         end
      end
   end

   // ---- saturation statistics on output transfers ----
   // A clear in the same cycle as a transfer still accounts for that
   // transfer, so no saturation event is lost across the clear.
   always_comb begin
      sat_cnt_d  = sat_cnt_q;
      sat_flag_d = sat_flag_q;
      if (sat_clr) begin
         sat_cnt_d  = xfer ? CW'(pc_p2) : '0;
         sat_flag_d = xfer && (pc_p2 != '0);
      end else if (xfer) begin
         sat_cnt_d  = cnt_add(sat_cnt_q, pc_p2);
         sat_flag_d = sat_flag_q || (pc_p2 != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_p1_q     <= 1'b0;
         t_p1_q     <= '0;
         v_p2_q     <= 1'b0;
         dat_p2_q   <= '0;
         sat_p2_q   <= '0;
         sat_cnt_q  <= '0;
         sat_flag_q <= 1'b0;
      end else begin
         v_p1_q     <= v_p1_d;
         t_p1_q     <= t_p1_d;
         v_p2_q     <= v_p2_d;
         dat_p2_q   <= dat_p2_d;
         sat_p2_q   <= sat_p2_d;
         sat_cnt_q  <= sat_cnt_d;
         sat_flag_q <= sat_flag_d;
      end
   end

endmodule

// File: tb/tb_acc_shift_rs.sv
module tb_acc_shift_rs;

   localparam int CH = 2;
   localparam int DW = 22;
   localparam int OW = 16;
   localparam int SW = 3;
   localparam int CW = 16;

   localparam bit RND =
`ifdef ACC_SHIFT_RS_ROUND_EN
      1'b1;
`else
      1'b0;
`endif

   logic                clk;
   logic                rst;
   logic                m_valid;
   logic                m_ready;
   logic [CH*DW-1:0]    m_data;
   logic [SW-1:0]       m_shift_n;
   logic                s_valid;
   logic                s_ready;
   logic [CH*OW-1:0]    s_data;
   logic [CH-1:0]       s_sat;
   logic                sat_clr;
   logic [CW-1:0]       sat_cnt;
   logic                sat_flag;

   acc_shift_rs #(.CH(CH), .DW(DW), .OW(OW), .SW(SW), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_shift_n(m_shift_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sat(s_sat),
      .sat_clr(sat_clr), .sat_cnt(sat_cnt), .sat_flag(sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [CH*OW-1:0] data;
      logic [CH-1:0]    sat;
   } exp_t;

   exp_t sbq[$];
   longint cnt_m;
   bit     flg_m;
   bit     prev_stall;
   logic [CH*OW+CH:0] prev_word;
   bit     last_acc, last_xfer;
   int     last_out;

   // Plain-integer rescale: floor((a + half) / 2^sh), then clamp.
   function automatic exp_t model_beat(input logic [CH*DW-1:0] d, input logic [SW-1:0] sh);
      exp_t r;
      for (int i = 0; i < CH; i++) begin
         longint a, dv, v, q;
         a  = longint'($signed(d[i*DW +: DW]));
         dv = longint'(1) << sh;
         v  = a;
         if (RND && sh != 0) v = v + dv / 2;
         q = v / dv;
         if ((v % dv) != 0 && v < 0) q = q - 1;
         r.sat[i] = 1'b0;
         if (q > 32767) begin
            q = 32767; r.sat[i] = 1'b1;
         end else if (q < -32768) begin
            q = -32768; r.sat[i] = 1'b1;
         end
         r.data[i*OW +: OW] = 16'(q);
      end
      return r;
   endfunction

   // Called once per cycle at the falling edge: inputs and outputs are
   // stable and describe what the next rising edge will do.
   task automatic sb_step();
      exp_t e;
      int   pc;
      bit   xf, ac;
      xf = s_valid && s_ready;
      ac = m_valid && m_ready;
      last_xfer = xf;
      last_acc  = ac;
      last_out  = int'($signed(s_data[15:0]));
      if (rst) begin
         sbq.delete();
         cnt_m = 0;
         flg_m = 0;
         prev_stall = 0;
         return;
      end
      check("sat_cnt", sat_cnt, cnt_m);
      check("sat_flag", sat_flag, flg_m);
      if (prev_stall) check("stall_hold", {s_valid, s_sat, s_data}, prev_word);
      prev_stall = s_valid && !s_ready;
      prev_word  = {s_valid, s_sat, s_data};
      pc = 0;
      if (xf) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_extra: output beat %0h, expected no beat (t=%0t)", s_data, $time);
         end else begin
            e = sbq.pop_front();
            check("sb_data", s_data, e.data);
            check("sb_sat", s_sat, e.sat);
            for (int i = 0; i < CH; i++) pc += int'(e.sat[i]);
         end
      end
      if (sat_clr) begin
         cnt_m = xf ? pc : 0;
         flg_m = xf && pc > 0;
      end else if (xf) begin
         cnt_m = cnt_m + pc;
         if (cnt_m > 65535) cnt_m = 65535;
         if (pc > 0) flg_m = 1;
      end
      if (ac) sbq.push_back(model_beat(m_data, m_shift_n));
   endtask

   task automatic tick();
      @(negedge clk);
      sb_step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_val();
      int v;
      case ($urandom_range(0, 2))
         0: begin v = $urandom_range(0, 4000); return DW'(v - 2000); end
         1: return DW'($urandom());
         default: begin v = $urandom_range(0, 200000); return DW'(v - 100000); end
      endcase
   endfunction

   typedef struct {
      logic signed [DW-1:0] d0, d1;
      logic [SW-1:0]        sh;
      logic signed [OW-1:0] e0, e1;
      logic [CH-1:0]        sat;
      logic [CW-1:0]        cnt;
   } vec_t;

   vec_t tbl[5];
   int   idx, got, stale;
   int   outs[4];
   int   ocyc[4];

   initial begin
      tbl[0] = '{22'sd5, -22'sd5, 3'd1, RND ? 16'sd3 : 16'sd2, RND ? -16'sd2 : -16'sd3, 2'b00, 16'd0};
      tbl[1] = '{22'sd40000, -22'sd40000, 3'd0, 16'sd32767, -16'sd32768, 2'b11, 16'd2};
      tbl[2] = '{22'sd40000, 22'sd0, 3'd2, 16'sd10000, 16'sd0, 2'b00, 16'd2};
      tbl[3] = '{-22'sd2097152, 22'sd2097151, 3'd7, -16'sd16384, RND ? 16'sd16384 : 16'sd16383, 2'b00, 16'd2};
      tbl[4] = '{22'sd2097151, 22'sd2097151, 3'd0, 16'sd32767, 16'sd32767, 2'b11, 16'd4};

      rst = 1'b1; m_valid = 1'b0; m_data = '0; m_shift_n = '0;
      s_ready = 1'b1; sat_clr = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // reset state
      check("rst_s_valid", s_valid, 0);
      check("rst_s_data", s_data, 0);
      check("rst_s_sat", s_sat, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      check("rst_sat_flag", sat_flag, 0);
      check("rst_m_ready", m_ready, 1);

      // single beats with exact latency
      for (int k = 0; k < 5; k++) begin
         m_valid = 1'b1; m_data = {tbl[k].d1, tbl[k].d0}; m_shift_n = tbl[k].sh;
         tick();
         m_valid = 1'b0;
         check("tbl_lat1_valid", s_valid, 0);
         tick();
         check("tbl_valid", s_valid, 1);
         check("tbl_data", s_data, {tbl[k].e1, tbl[k].e0});
         check("tbl_sat", s_sat, tbl[k].sat);
         tick();
         check("tbl_cnt", sat_cnt, tbl[k].cnt);
      end

      // backpressure: 4 beats, output blocked for 5 cycles
      s_ready = 1'b0; idx = 0;
      for (int c = 0; c < 5; c++) begin
         m_valid = (idx < 4);
         m_data = {DW'(-(idx + 1)), DW'(idx + 1)}; m_shift_n = '0;
         tick();
         if (last_acc) idx++;
         if (c >= 1) begin
            check("bp_hold_valid", s_valid, 1);
            check("bp_hold_data", s_data, 32'hFFFF_0001);
         end
      end
      check("bp_accepted", idx, 2);
      check("bp_m_ready", m_ready, 0);
      s_ready = 1'b1; got = 0;
      for (int c = 0; c < 10 && got < 4; c++) begin
         m_valid = (idx < 4);
         m_data = {DW'(-(idx + 1)), DW'(idx + 1)};
         tick();
         if (last_xfer) begin
            outs[got] = last_out; ocyc[got] = c; got++;
         end
         if (last_acc) idx++;
      end
      m_valid = 1'b0;
      check("bp_count", got, 4);
      for (int k = 0; k < 4; k++) begin
         check("bp_order", outs[k], k + 1);
         check("bp_nogap", ocyc[k], k);
      end

      // sat_clr coinciding with a saturating transfer, then alone
      m_valid = 1'b1; m_data = {22'sd5, 22'sd40000}; m_shift_n = '0;
      tick();
      m_valid = 1'b0;
      tick();
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      check("clr_xfer_cnt", sat_cnt, 1);
      check("clr_xfer_flag", sat_flag, 1);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      check("clr_only_cnt", sat_cnt, 0);
      check("clr_only_flag", sat_flag, 0);

      // reset with both stages full
      m_valid = 1'b1; m_data = {-22'sd40000, 22'sd40000};
      tick();
      m_valid = 1'b0;
      repeat (2) tick();
      s_ready = 1'b0;
      m_valid = 1'b1; m_data = {22'sd1, 22'sd1};
      tick();
      m_data = {22'sd2, 22'sd2};
      tick();
      m_valid = 1'b0;
      check("full_m_ready", m_ready, 0);
      check("full_s_valid", s_valid, 1);
      check("full_cnt", sat_cnt, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_s_valid", s_valid, 0);
      check("mid_rst_s_data", s_data, 0);
      check("mid_rst_sat_cnt", sat_cnt, 0);
      check("mid_rst_sat_flag", sat_flag, 0);
      check("mid_rst_m_ready", m_ready, 1);
      s_ready = 1'b1; stale = 0;
      repeat (6) begin
         tick();
         if (last_xfer) stale++;
      end
      check("mid_rst_no_stale", stale, 0);

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         m_valid   = ($urandom_range(0, 9) < 7);
         s_ready   = ($urandom_range(0, 9) < 7);
         sat_clr   = ($urandom_range(0, 19) == 0);
         m_shift_n = SW'($urandom());
         for (int ch = 0; ch < CH; ch++) m_data[ch*DW +: DW] = rnd_val();
         tick();
      end
      m_valid = 1'b0; sat_clr = 1'b0; s_ready = 1'b1;
      repeat (6) tick();
      check("drain_empty", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
